// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // clk cycles per oversample tick; clamped so a too-fast baud still ticks every cycle
  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned d;
    d = clock_freq / (baud_rate * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head entry is visible with no read latency.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // a pop frees the slot a same-cycle push needs when full
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority voting, parity/frame/break detection
// and a receive FIFO carrying per-word error flags.
module uart_rx_core import uart_pkg::*; #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned MSB_FIRST   = 0,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rx_ready,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam int unsigned WW  = DATA_BITS + 2;
  localparam int unsigned MID = OVERSAMPLE / 2;

  rx_state_t            state;
  rx_state_t            next_state;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  logic [DCW-1:0]       div_cnt;
  logic [SCW-1:0]       samp_cnt;
  logic [1:0]           ones;
  logic [BCW-1:0]       bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 tick;
  logic                 bit_end;
  logic                 in_window;
  logic                 last_sample;
  logic                 maj;
  logic                 last_stop;
  logic                 brk_cond;
  logic                 push;
  logic                 brk_hit;
  logic                 word_perr;
  logic                 word_ferr;
  logic                 fifo_full;
  logic                 pop;
  logic [WW-1:0]        head;

  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign tick        = (state != ST_IDLE) && (div_cnt == DCW'(DIV - 1));
  assign bit_end     = tick && (samp_cnt == SCW'(OVERSAMPLE - 1));
  assign in_window   = tick && (samp_cnt >= SCW'(MID - 1)) && (samp_cnt <= SCW'(MID + 1));
  assign last_sample = tick && (samp_cnt == SCW'(MID + 1));
  // ones holds the first two votes; the third is the live sample
  assign maj         = (ones + 2'(rx_s2)) >= 2'd2;
  assign last_stop   = (stop_idx == 1'(STOP_BITS - 1));
  assign brk_cond    = !stop_idx && !maj && (shreg == '0) &&
                       ((PARITY_MODE == PARITY_NONE) || !par_bit);
  assign word_ferr   = ferr_acc || !maj;
  assign word_perr   = (PARITY_MODE != PARITY_NONE) &&
                       (((^shreg) ^ par_bit) != (PARITY_MODE == PARITY_ODD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (rx_prev && !rx_s2) next_state = ST_START;
      ST_START: begin
        if (last_sample && maj) next_state = ST_IDLE;
        else if (bit_end)       next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == BCW'(DATA_BITS - 1)))
          next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) next_state = ST_STOP;
      ST_STOP: begin
        if (last_sample) begin
          if (brk_cond)       next_state = ST_BREAK;
          else if (last_stop) next_state = ST_IDLE;
        end
      end
      ST_BREAK:  if (rx_s2) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // word leaves at the mid-sample of the final stop bit
  always_comb begin
    push    = 1'b0;
    brk_hit = 1'b0;
    if ((state == ST_STOP) && last_sample) begin
      if (brk_cond)       brk_hit = 1'b1;
      else if (last_stop) push    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      samp_cnt  <= '0;
      ones      <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      ferr_acc  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
        ones     <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DCW'(1);
        if (bit_end) begin
          samp_cnt <= '0;
          ones     <= '0;
        end else if (tick) begin
          samp_cnt <= samp_cnt + SCW'(1);
          if (in_window) ones <= ones + 2'(rx_s2);
        end
        if ((state == ST_DATA) && last_sample) begin
          if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], maj};
          else                shreg <= {maj, shreg[DATA_BITS-1:1]};
        end
        if ((state == ST_DATA) && bit_end)          bit_idx  <= bit_idx + BCW'(1);
        if ((state == ST_PARITY) && last_sample)    par_bit  <= maj;
        if ((state == ST_STOP) && last_sample && !maj) ferr_acc <= 1'b1;
        if ((state == ST_STOP) && bit_end)          stop_idx <= 1'b1;
      end
      break_det <= brk_hit;
    end
  end

  assign pop = rx_valid && rx_ready;

  // set beats clear so a drop coinciding with err_clr is not lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               overrun_err <= 1'b0;
    else if (push && fifo_full && !pop)     overrun_err <= 1'b1;
    else if (err_clr)                       overrun_err <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({word_ferr, word_perr, shreg}),
    .pop   (pop),
    .rdata (head),
    .valid (rx_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rx_data    = head[DATA_BITS-1:0];
  assign parity_err = head[DATA_BITS];
  assign frame_err  = head[DATA_BITS+1];

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLOCK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, 8..16).
REQ-005 SHALL have parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-007 SHALL have parameter MSB_FIRST, default 0: 0 LSB received first, 1 MSB first.
REQ-008 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, >=2).
REQ-009 Ports: clk  in  1  system clock; all logic on rising edge.
REQ-010 Ports: rst  in  1  reset, asynchronous assert, active-low.
REQ-011 Ports: rx  in  1  asynchronous serial line, idle high.
REQ-012 Ports: rx_ready  in  1  consumer pops FIFO head when rx_valid&rx_ready.
REQ-013 Ports: err_clr  in  1  one-cycle pulse clearing sticky overrun_err.
REQ-014 Ports: rx_data  out  DATA_BITS  FIFO head data.
REQ-015 Ports: rx_valid  out  1  FIFO non-empty.
REQ-016 Ports: parity_err / frame_err  out  1 each  per-word flags travelling with rx_data.
REQ-017 Ports: overrun_err  out  1  sticky: word lost to full FIFO.
REQ-018 Ports: break_det  out  1  one-cycle pulse on line break.
REQ-019 Ports: fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-020 rx SHALL pass a 2-flop synchroniser before any use; sync flops reset to 1.
REQ-021 Sample tick SHALL pulse once every CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clk cycles (integer division); divider free-runs only outside IDLE and restarts at 0 on falling-edge detection.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-023 IDLE->START on synchronised rx 1->0.
REQ-024 Each bit value SHALL be the majority of samples at ticks OVERSAMPLE/2-1, /2, /2+1 of that bit.
REQ-025 START: majority 1 -> false start, return to IDLE, nothing pushed; majority 0 -> DATA at bit end.
REQ-026 DATA: collect DATA_BITS bits in MSB_FIRST order; then PARITY if PARITY_MODE!=0 else STOP.
REQ-027 PARITY: parity_err = (XOR of data bits ^ sampled bit) != (PARITY_MODE==2).
REQ-028 STOP: each of STOP_BITS bits sampled; any 0 sets frame_err for the word.
REQ-029 Word SHALL be pushed at the mid-sample of the last stop bit (not bit end); FSM returns to IDLE there, allowing back-to-back frames with half-bit margin.
REQ-030 Break: all data bits 0, parity (if any) 0 and first stop bit 0 -> no push, break_det pulse, enter BREAK; BREAK->IDLE when synchronised rx is 1.
REQ-031 FIFO stores {frame_err, parity_err, data}; outputs are head entry, first-word-fall-through, zero-cycle read latency.
REQ-032 Push while full: word dropped, overrun_err set; push and pop same cycle when full: both succeed.
REQ-033 Pop when empty: ignored; simultaneous push and pop when empty: word written, rx_valid rises next cycle.
REQ-034 overrun_err clears on err_clr; set wins over clear in the same cycle.
REQ-035 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Reset
REQ-036 rst low SHALL immediately force FSM IDLE, divider/bit counters 0, FIFO empty, rx_valid/overrun_err/break_det/parity_err/frame_err 0, rx_data 0.
REQ-037 Reset mid-frame SHALL discard the partial word; after release the block waits for a fresh falling edge.

Structure
REQ-038 Package uart_pkg SHALL hold the FSM state enum, parity-mode constants and the divider computation function.
REQ-039 FIFO SHALL be a separate sub-module uart_rx_fifo (parameters WIDTH, DEPTH).

Verification
REQ-040 8N1, 9600 baud, 50 MHz, send 0xA5 LSB-first -> rx_data=0xA5, rx_valid=1, no error flags.
REQ-041 PARITY_MODE=1, send 0x07 with parity bit 0 -> parity_err=1 with rx_data=0x07.
REQ-042 0.25-bit low glitch on idle line -> nothing pushed, FSM back in IDLE.
REQ-043 rx_ready=0, send FIFO_DEPTH+1 words -> fifo_count=8, overrun_err=1, first 8 words intact; err_clr -> overrun_err=0.
REQ-044 Hold rx low 2 frame times -> single break_det pulse, no push; rx high -> next 0x3C received correctly.
REQ-045 Assert rst mid-DATA of 0x55, release, send 0x81 -> only 0x81 appears.
